// File: rtl/rmii_rx_deframer.sv
// -----------------------------------------------------------------------------
// rmii_rx_deframer
//
// Receive-side front end for one RMII PHY port. Samples crs_dv/rx_d/rx_er on
// the 50 MHz RMII reference clock, strips preamble and SFD, and reassembles
// LSB-first dibits into bytes. Emits one byte strobe per completed byte plus a
// per-frame completion record (length, error summary, FCS result).
//
// Optional feature macro: RMII_RX_FCS_CHECK_EN
//   defined   -> CRC-32 residue check over every counted byte (FCS included);
//                fcs_ok reports the result and a mismatch sets frame_err.
//   undefined -> no CRC logic; fcs_ok is tied 0.
//
// Ports:
//   clk         in   RMII reference clock (sole clock)
//   resetn      in   synchronous, active-low reset
//   crs_dv      in   carrier sense / data valid
//   rx_d[1:0]   in   receive dibit, rx_d[0] transmitted first
//   rx_er       in   receive error
//   m_data[7:0] out  received byte
//   m_valid     out  one-cycle byte strobe
//   m_sof       out  first byte after SFD (qualifies m_valid)
//   frame_done  out  one-cycle pulse at end of a frame that passed SFD
//   frame_len   out  complete bytes in the frame (valid with frame_done)
//   frame_err   out  frame error summary (valid with frame_done)
//   fcs_ok      out  FCS residue check result (valid with frame_done)
//   busy        out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module rmii_rx_deframer #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int LEN_W           = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             crs_dv,
  input  logic [1:0]       rx_d,
  input  logic             rx_er,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err,
  output logic             fcs_ok,
  output logic             busy
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [1:0]       dibit_cnt_q, dibit_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             err_q, err_d;
  // DROP: remembers that the previous cycle already had crs_dv low.
  logic             drop_low_q, drop_low_d;

  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_sof_q, m_sof_d;
  logic             frame_done_q, frame_done_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             frame_err_q, frame_err_d;

  logic [7:0]       byte_nxt;
  logic             err_n;
  logic             fcs_bad;

`ifdef RMII_RX_FCS_CHECK_EN
  // Residue of a good frame, expressed MSB-first; the reflected register holds
  // its bit-reverse.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [31:0] crc_q, crc_d;
  logic        fcs_ok_q, fcs_ok_d;

  // Reflected CRC-32 (poly 0x04C11DB7 -> reversed 0xEDB88320), one byte,
  // LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign fcs_bad = (bitrev32(crc_q) != CRC_RESIDUE);
  assign fcs_ok  = fcs_ok_q;
`else
  assign fcs_bad = 1'b0;
  assign fcs_ok  = 1'b0;
`endif

  // Byte as it will look once the current dibit is shifted in (LSB first).
  assign byte_nxt = {rx_d, sr_q[7:2]};

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    dibit_cnt_d  = dibit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    err_d        = err_q;
    drop_low_d   = drop_low_q;
    m_data_d     = m_data_q;
    m_valid_d    = 1'b0;
    m_sof_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    frame_err_d  = frame_err_q;
`ifdef RMII_RX_FCS_CHECK_EN
    crc_d        = crc_q;
    fcs_ok_d     = fcs_ok_q;
`endif
    err_n        = err_q | rx_er;

    case (state_q)
      S_IDLE: begin
        if (crs_dv) begin
          if (rx_d == 2'b01) begin
            state_d = S_PREAMBLE;
          end else begin
            state_d    = S_DROP;
            drop_low_d = 1'b0;
          end
        end
      end

      S_PREAMBLE: begin
        if (!crs_dv) begin
          state_d = S_IDLE;
        end else begin
          case (rx_d)
            2'b01: state_d = S_PREAMBLE;
            2'b11: begin
              // SFD: start a fresh frame.
              state_d     = S_DATA;
              dibit_cnt_d = 2'd0;
              byte_cnt_d  = '0;
              err_d       = 1'b0;
`ifdef RMII_RX_FCS_CHECK_EN
              crc_d       = 32'hFFFFFFFF;
`endif
            end
            default: begin
              state_d    = S_DROP;
              drop_low_d = 1'b0;
            end
          endcase
        end
      end

      S_DATA: begin
        // crs_dv low at dibit 2 is RMII carrier toggling, not end of frame.
        if (crs_dv || (dibit_cnt_q == 2'd2)) begin
          sr_d        = byte_nxt;
          dibit_cnt_d = dibit_cnt_q + 2'd1;
          if (dibit_cnt_q == 2'd3) begin
            if (byte_cnt_q == MAX_CNT) begin
              err_n = 1'b1;
            end else begin
              m_data_d   = byte_nxt;
              m_valid_d  = 1'b1;
              m_sof_d    = (byte_cnt_q == '0);
              byte_cnt_d = byte_cnt_q + LEN_W'(1);
`ifdef RMII_RX_FCS_CHECK_EN
              crc_d      = crc32_byte(crc_q, byte_nxt);
`endif
            end
          end
        end else begin
          // End of frame; an odd dibit count means a partial trailing byte.
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          frame_len_d  = byte_cnt_q;
          frame_err_d  = err_n | dibit_cnt_q[0] | (byte_cnt_q == '0) | fcs_bad;
`ifdef RMII_RX_FCS_CHECK_EN
          fcs_ok_d     = ~fcs_bad;
`endif
        end
        err_d = err_n;
      end

      S_DROP: begin
        if (crs_dv) begin
          drop_low_d = 1'b0;
        end else if (drop_low_q) begin
          state_d    = S_IDLE;
          drop_low_d = 1'b0;
        end else begin
          drop_low_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      dibit_cnt_q  <= '0;
      byte_cnt_q   <= '0;
      err_q        <= 1'b0;
      drop_low_q   <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_sof_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      frame_err_q  <= 1'b0;
`ifdef RMII_RX_FCS_CHECK_EN
      crc_q        <= 32'hFFFFFFFF;
      fcs_ok_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      dibit_cnt_q  <= dibit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      err_q        <= err_d;
      drop_low_q   <= drop_low_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_sof_q      <= m_sof_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      frame_err_q  <= frame_err_d;
`ifdef RMII_RX_FCS_CHECK_EN
      crc_q        <= crc_d;
      fcs_ok_q     <= fcs_ok_d;
`endif
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_sof      = m_sof_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
